rvvi_cmd_decoder: RTL and testbench

Parametrised host-command decoder for the RVVI hardware tracer. It parses frames arriving on the Ethernet MAC receive AXI-stream and matches each frame header against `NUM_CMDS` programmable compare strings. On a match it emits a one-cycle command pulse with captured argument words. It replaces the fixed single-string trigger and slow-down paths: it adds argument capture, bad/short-frame rejection with a drop counter, and a built-in host-stall timer.

---
 rtl/rvvi_cmd_decoder.sv | 132 +++++++++++++
 tb/tb_rvvi_cmd_decoder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvvi_cmd_decoder.sv
// Host-command decoder for the RVVI tracer: matches receive-stream frame headers
// against NUM_CMDS programmable strings, captures argument words and drives a host-stall timer.
module rvvi_cmd_decoder #(
  parameter int DATA_W    = 32,
  parameter int NUM_CMDS  = 2,
  parameter int HDR_WORDS = 5,
  parameter int ARG_WORDS = 1,
  parameter int STALL_CMD = 1,
  parameter int STALL_W   = 32
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic [NUM_CMDS*HDR_WORDS*DATA_W-1:0]  CompareStrings,
  input  logic [DATA_W-1:0]                     RvviAxiRdata,
  input  logic [DATA_W/8-1:0]                   RvviAxiRstrb,
  input  logic                                  RvviAxiRvalid,
  input  logic                                  RvviAxiRlast,
  input  logic                                  RvviAxiRuser,
  output logic [NUM_CMDS-1:0]                   CmdPulse,
  output logic [ARG_WORDS*DATA_W-1:0]           CmdArg,
  output logic                                  HostStall,
  output logic [15:0]                           FrameDropCount
);

  localparam int TOTAL = HDR_WORDS + ARG_WORDS;
  localparam int IDX_W = $clog2(TOTAL + 1);
  localparam logic [IDX_W-1:0] IDX_TOP      = IDX_W'(TOTAL);
  localparam logic [IDX_W-1:0] IDX_HDR_LAST = IDX_W'(HDR_WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_ARG_LAST = IDX_W'(TOTAL - 1);

  typedef enum logic [1:0] {S_HDR, S_ARG, S_DRAIN} state_t;

  state_t                      state;
  logic [IDX_W-1:0]            idx;
  logic [NUM_CMDS-1:0]         m;
  logic [ARG_WORDS*DATA_W-1:0] shadow;
  logic [STALL_W-1:0]          stall_cnt;

  logic [NUM_CMDS-1:0]         m_next;
  logic [NUM_CMDS-1:0]         sel;
  logic [ARG_WORDS*DATA_W-1:0] shadow_next;
  logic [DATA_W-1:0]           hdr_word;
  logic                        long_enough;
  logic                        accept;
  logic                        drop;
  logic [STALL_W-1:0]          stall_new;

  // Header compare for the current beat; a partial strobe never matches.
  always_comb begin
    m_next   = m;
    hdr_word = '0;
    if (state == S_HDR) begin
      for (int c = 0; c < NUM_CMDS; c++) begin
        hdr_word = '0;
        for (int b = 0; b < HDR_WORDS; b++) begin
          if (idx == IDX_W'(b))
            hdr_word = CompareStrings[(c*HDR_WORDS + b)*DATA_W +: DATA_W];
        end
        if (!(&RvviAxiRstrb) || (RvviAxiRdata != hdr_word))
          m_next[c] = 1'b0;
      end
    end
  end

  // The shadow view includes this beat so a last beat carrying an argument commits it.
  always_comb begin
    shadow_next = shadow;
    if (state == S_ARG) begin
      for (int a = 0; a < ARG_WORDS; a++) begin
        if (idx == IDX_W'(HDR_WORDS + a))
          shadow_next[a*DATA_W +: DATA_W] = RvviAxiRdata;
      end
    end
  end

  always_comb begin
    long_enough = (idx >= IDX_ARG_LAST);
    accept      = RvviAxiRvalid && RvviAxiRlast && (|m_next) && long_enough && !RvviAxiRuser;
    drop        = RvviAxiRvalid && RvviAxiRlast && (!long_enough || RvviAxiRuser);
    sel         = m_next & (~m_next + NUM_CMDS'(1));
    stall_new   = shadow_next[STALL_W-1:0];
  end

  // m resets to all ones because reset is also the start of a frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= S_HDR;
      idx            <= '0;
      m              <= '1;
      shadow         <= '0;
      stall_cnt      <= '0;
      CmdPulse       <= '0;
      CmdArg         <= '0;
      FrameDropCount <= '0;
    end else begin
      CmdPulse <= '0;
      if (accept) begin
        CmdPulse <= sel;
        CmdArg   <= shadow_next;
      end

      if (drop && (FrameDropCount != 16'hFFFF))
        FrameDropCount <= FrameDropCount + 16'd1;

      if (accept && sel[STALL_CMD])
        stall_cnt <= (stall_new > stall_cnt) ? stall_new : stall_cnt;
      else if (stall_cnt != '0)
        stall_cnt <= stall_cnt - STALL_W'(1);

      if (RvviAxiRvalid) begin
        shadow <= shadow_next;
        if (RvviAxiRlast) begin
          state <= S_HDR;
          idx   <= '0;
          m     <= '1;
        end else begin
          m <= m_next;
          if (idx != IDX_TOP)
            idx <= idx + IDX_W'(1);
          case (state)
            S_HDR:   if (idx == IDX_HDR_LAST) state <= (|m_next) ? S_ARG : S_DRAIN;
            S_ARG:   if (idx == IDX_ARG_LAST) state <= S_DRAIN;
            default: state <= S_DRAIN;
          endcase
        end
      end
    end
  end

  assign HostStall = (stall_cnt != '0);

endmodule

// File: tb/tb_rvvi_cmd_decoder.sv
// Self-checking bench for rvvi_cmd_decoder: table-driven frames with a scoreboard
// of expected pulses, plus hand-written reset and identical-string sequences.
module tb_rvvi_cmd_decoder;

  localparam int DATA_W    = 32;
  localparam int NUM_CMDS  = 2;
  localparam int HDR_WORDS = 5;
  localparam int ARG_WORDS = 1;
  localparam int STALL_CMD = 1;
  localparam int STALL_W   = 32;
  localparam int TOTAL     = HDR_WORDS + ARG_WORDS;
  localparam int NVEC      = 16;

  typedef struct {
    int          chan;
    int          nbeats;
    int          corrupt;
    logic        strb_bad;
    logic        user;
    int          gap;
    logic [31:0] arg;
    logic [1:0]  exp_pulse;
    logic [31:0] exp_arg;
    logic [15:0] exp_drop;
  } vec_t;

  typedef struct {
    logic [1:0]  pulse;
    logic [31:0] arg;
    logic [15:0] drop;
  } exp_t;

  logic                                 clk = 1'b0;
  logic                                 resetn;
  logic [NUM_CMDS*HDR_WORDS*DATA_W-1:0] compare_strings;
  logic [DATA_W-1:0]                    rdata;
  logic [DATA_W/8-1:0]                  rstrb;
  logic                                 rvalid;
  logic                                 rlast;
  logic                                 ruser;
  logic [NUM_CMDS-1:0]                  cmd_pulse;
  logic [ARG_WORDS*DATA_W-1:0]          cmd_arg;
  logic                                 host_stall;
  logic [15:0]                          drop_count;

  logic [31:0] cmp_words [NUM_CMDS][HDR_WORDS];
  vec_t        vecs [NVEC];
  exp_t        sb_q [$];
  int          checks = 0;
  int          errors = 0;
  logic        last_seen = 1'b0;
  logic [STALL_W-1:0] model_cnt = '0;

  rvvi_cmd_decoder #(
    .DATA_W(DATA_W), .NUM_CMDS(NUM_CMDS), .HDR_WORDS(HDR_WORDS),
    .ARG_WORDS(ARG_WORDS), .STALL_CMD(STALL_CMD), .STALL_W(STALL_W)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .CompareStrings(compare_strings),
    .RvviAxiRdata(rdata),
    .RvviAxiRstrb(rstrb),
    .RvviAxiRvalid(rvalid),
    .RvviAxiRlast(rlast),
    .RvviAxiRuser(ruser),
    .CmdPulse(cmd_pulse),
    .CmdArg(cmd_arg),
    .HostStall(host_stall),
    .FrameDropCount(drop_count)
  );

  always #5 clk = ~clk;

  always_comb begin
    compare_strings = '0;
    for (int c = 0; c < NUM_CMDS; c++)
      for (int b = 0; b < HDR_WORDS; b++)
        compare_strings[(c*HDR_WORDS + b)*DATA_W +: DATA_W] = cmp_words[c][b];
  end

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rvalid = 1'b0;
      rlast  = 1'b0;
      ruser  = 1'b0;
      rstrb  = 4'hF;
    end
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic [3:0] s, input logic l, input logic u);
    @(posedge clk);
    #1;
    rvalid = 1'b1;
    rdata  = d;
    rstrb  = s;
    rlast  = l;
    ruser  = u;
  endtask

  function automatic logic [31:0] frame_word(input int chan, input int b, input logic [31:0] arg);
    if (b < HDR_WORDS) return cmp_words[chan][b];
    if (b < TOTAL) return arg;
    return 32'hDEAD_0000 | 32'(b);
  endfunction

  task automatic apply_stimulus(input vec_t v);
    exp_t        e;
    logic [31:0] d;
    logic [3:0]  s;
    logic        l;
    idle(v.gap);
    e.pulse = v.exp_pulse;
    e.arg   = v.exp_arg;
    e.drop  = v.exp_drop;
    sb_q.push_back(e);
    for (int b = 0; b < v.nbeats; b++) begin
      d = frame_word(v.chan, b, v.arg);
      s = 4'hF;
      if (b == v.corrupt) begin
        if (v.strb_bad) s = 4'b0111;
        else d = d ^ 32'h0000_0100;
      end
      l = (b == v.nbeats - 1);
      drive_beat(d, s, l, l ? v.user : 1'b0);
    end
  endtask

  task automatic push_expect(input logic [1:0] p, input logic [31:0] a, input logic [15:0] dc);
    exp_t e;
    e.pulse = p;
    e.arg   = a;
    e.drop  = dc;
    sb_q.push_back(e);
  endtask

  always @(posedge clk) last_seen <= resetn && rvalid && rlast;

  // Scoreboard pop on the pulse cycle, plus an independent stall-counter model.
  always @(negedge clk) begin
    exp_t        e;
    logic        load;
    logic [31:0] nv;
    if (!resetn) begin
      model_cnt = '0;
    end else begin
      load = 1'b0;
      nv   = '0;
      if (last_seen) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL scoreboard_empty actual=pulse %0h expected=queued entry", cmd_pulse);
        end else begin
          e = sb_q.pop_front();
          check_output("cmd_pulse", 64'(cmd_pulse), 64'(e.pulse));
          check_output("cmd_arg", 64'(cmd_arg), 64'(e.arg));
          check_output("drop_count", 64'(drop_count), 64'(e.drop));
          if (e.pulse[STALL_CMD]) begin
            load = 1'b1;
            nv   = e.arg;
          end
        end
      end else begin
        check_output("idle_pulse", 64'(cmd_pulse), 64'd0);
      end
      if (load) model_cnt = (nv > model_cnt) ? nv : model_cnt;
      else if (model_cnt != 0) model_cnt = model_cnt - 1;
      check_output("host_stall", 64'(host_stall), 64'(model_cnt != 0));
    end
  end

  initial begin
    for (int c = 0; c < NUM_CMDS; c++)
      for (int b = 0; b < HDR_WORDS; b++)
        cmp_words[c][b] = (c == 0 ? 32'hC0DE_0000 : 32'h5A11_0000) + 32'(b);

    //            chan nb corr strb  user  gap arg           pulse  exp_arg       drop
    vecs[0]  = '{0, 6, -1, 1'b0, 1'b0, 2,  32'h0000_0040, 2'b01, 32'h0000_0040, 16'd0};
    vecs[1]  = '{1, 6, -1, 1'b0, 1'b0, 2,  32'd3,         2'b10, 32'd3,         16'd0};
    vecs[2]  = '{1, 6, -1, 1'b0, 1'b0, 8,  32'd8,         2'b10, 32'd8,         16'd0};
    vecs[3]  = '{1, 6, -1, 1'b0, 1'b0, 0,  32'd10,        2'b10, 32'd10,        16'd0};
    vecs[4]  = '{0, 5, -1, 1'b0, 1'b0, 12, 32'h0000_0011, 2'b00, 32'd10,        16'd1};
    vecs[5]  = '{0, 6, -1, 1'b0, 1'b1, 2,  32'h0000_0077, 2'b00, 32'd10,        16'd2};
    vecs[6]  = '{0, 6, 2,  1'b0, 1'b0, 2,  32'h0000_0055, 2'b00, 32'd10,        16'd2};
    vecs[7]  = '{0, 6, -1, 1'b0, 1'b0, 0,  32'h0000_0099, 2'b01, 32'h0000_0099, 16'd2};
    vecs[8]  = '{1, 6, 0,  1'b1, 1'b0, 2,  32'h0000_0066, 2'b00, 32'h0000_0099, 16'd2};
    vecs[9]  = '{0, 6, -1, 1'b0, 1'b0, 0,  32'h0000_1234, 2'b01, 32'h0000_1234, 16'd2};
    vecs[10] = '{0, 8, -1, 1'b0, 1'b0, 2,  32'h0000_00AB, 2'b01, 32'h0000_00AB, 16'd2};
    vecs[11] = '{1, 1, -1, 1'b0, 1'b0, 2,  32'd0,         2'b00, 32'h0000_00AB, 16'd3};
    vecs[12] = '{1, 3, -1, 1'b0, 1'b1, 2,  32'd0,         2'b00, 32'h0000_00AB, 16'd4};
    vecs[13] = '{1, 6, -1, 1'b0, 1'b0, 2,  32'd0,         2'b10, 32'd0,         16'd4};
    vecs[14] = '{1, 6, -1, 1'b0, 1'b0, 3,  32'd20,        2'b10, 32'd20,        16'd4};
    vecs[15] = '{1, 6, -1, 1'b0, 1'b0, 0,  32'd2,         2'b10, 32'd2,         16'd4};

    resetn = 1'b0;
    rvalid = 1'b0;
    rlast  = 1'b0;
    ruser  = 1'b0;
    rdata  = '0;
    rstrb  = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_pulse", 64'(cmd_pulse), 64'd0);
    check_output("reset_arg", 64'(cmd_arg), 64'd0);
    check_output("reset_stall", 64'(host_stall), 64'd0);
    check_output("reset_drop", 64'(drop_count), 64'd0);
    resetn = 1'b1;

    for (int i = 0; i < NVEC; i++) apply_stimulus(vecs[i]);
    idle(40);

    // Reset asserted mid-stall and mid-frame; the remainder becomes a short frame.
    apply_stimulus('{1, 6, -1, 1'b0, 1'b0, 2, 32'd30, 2'b10, 32'd30, 16'd4});
    idle(4);
    drive_beat(cmp_words[0][0], 4'hF, 1'b0, 1'b0);
    drive_beat(cmp_words[0][1], 4'hF, 1'b0, 1'b0);
    drive_beat(cmp_words[0][2], 4'hF, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    resetn = 1'b0;
    rvalid = 1'b0;
    #1;
    check_output("async_reset_stall", 64'(host_stall), 64'd0);
    check_output("async_reset_pulse", 64'(cmd_pulse), 64'd0);
    check_output("async_reset_drop", 64'(drop_count), 64'd0);
    @(posedge clk);
    #3;
    resetn = 1'b1;
    push_expect(2'b00, 32'd0, 16'd1);
    drive_beat(cmp_words[0][3], 4'hF, 1'b0, 1'b0);
    drive_beat(cmp_words[0][4], 4'hF, 1'b0, 1'b0);
    drive_beat(32'h0000_0123, 4'hF, 1'b1, 1'b0);
    apply_stimulus('{0, 6, -1, 1'b0, 1'b0, 3, 32'd5, 2'b01, 32'd5, 16'd1});
    idle(4);

    // Identical strings on both channels: only channel 0 fires, no stall.
    for (int b = 0; b < HDR_WORDS; b++) cmp_words[1][b] = cmp_words[0][b];
    apply_stimulus('{1, 6, -1, 1'b0, 1'b0, 3, 32'd7, 2'b01, 32'd7, 16'd1});
    idle(3);
    check_output("identical_no_stall", 64'(host_stall), 64'd0);

    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(posedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain actual=%0d pending expected=0", sb_q.size());
    end
    idle(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
